fb_port_arbiter: RTL and testbench
==================================

# fb_port_arbiter

Single-port arbiter and scroll sequencer for the character framebuffer RAM of the VGA text controller. It multiplexes three requesters onto one framebuffer RAM port: display fetch, CPU command writes drained from the command buffer, and an internal scroll/copy engine that moves text rows up during blanking. It sits between the command-buffer drain logic and video fetch pipeline on one side and the framebuffer BRAM on the other.

## Interface
- ADDR_W, 13, framebuffer address width
- H_CHARS, 80, characters per text row
- V_CHARS, 60, text rows per screen
- FILL_CHAR, 8'h20, byte written into vacated rows (fill feature only)
- CLK_FAST  in  1  sole clock; all logic on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- disp_req  in  1  display fetch request (held while DE)
- disp_addr  in  ADDR_W  display read address
- disp_rdata  out  8  read data to video pipeline
- disp_valid  out  1  disp_rdata valid this cycle
- cpu_req  in  1  CPU write pending; held until cpu_ack
- cpu_addr  in  ADDR_W  CPU write address
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle pulse: write issued
- blank  in  1  high outside active video; scroll may use RAM only when high
- scroll_start  in  1  one-cycle pulse starting a scroll
- scroll_lines  in  8  rows to scroll up
- scroll_busy  out  1  engine active
- scroll_done  out  1  one-cycle pulse at completion
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  8  RAM write data (registered)
- ram_rdata  in  8  RAM read data, one cycle after address

## Operation
- Fixed priority per cycle: display > CPU > scroll. Scroll is eligible only when blank=1 and neither higher requester is active.
- Exactly one grant per cycle; idle cycles drive ram_we=0 and hold ram_addr.
- A 2-bit owner tag travels with each read so returned data goes to display or scroll, never both. disp_valid is asserted only for display-owned reads.
- Scroll engine states: IDLE, RD, WAIT, WR, FILL, DONE.
  - IDLE: on scroll_start, clamp N=min(scroll_lines, V_CHARS), then set dst=0, copy count C=(V_CHARS-N)*H_CHARS, and busy=1.
    - N=0 goes straight to DONE.
    - C=0 goes straight to FILL, or to DONE when fill is compiled out.
  - RD: request a read of dst+N*H_CHARS; on grant go to WAIT.
  - WAIT: capture scroll-tagged return data, then go to WR.
  - WR: request a write of the captured byte to dst; on grant, dst+1. Go to RD while dst<C, otherwise to FILL or DONE.
  - FILL: write FILL_CHAR to dst, dst+1 per grant, until dst=V_CHARS*H_CHARS; then go to DONE.
  - DONE: pulse scroll_done, clear busy, return to IDLE.
- scroll_start while busy is ignored.
- Offset arithmetic is 14 bits internal; results are always below V_CHARS*H_CHARS, so no wrap occurs.
- CPU writes during a scroll are allowed. Ordering between a CPU write and an in-flight copy of the same address is not guaranteed; software waits for scroll_done.

## Timing
- Reset values: disp_valid=0, disp_rdata=0, cpu_ack=0, scroll_busy=0, scroll_done=0, ram_we=0, ram_addr=0, ram_wdata=0; engine returns to IDLE.
- Reset mid-scroll aborts the scroll: no done pulse, no further writes.
- If a request is sampled and granted at edge E, ram_* is valid after E and cpu_ack pulses in the same cycle.
- ram_rdata is sampled at E+2. disp_valid/disp_rdata are high in the cycle after E+2, so display read latency is 2 cycles.
- Back-to-back display reads sustain one per cycle.
- cpu_req is still high in the cycle cpu_ack pulses; the arbiter does not regrant until the requester drops or changes the request (ack-then-reissue needs a 1-cycle gap).
- If blank drops mid-scroll, the engine stalls in its current state. An issued read still returns and is captured.
- Minimum copy step is 4 cycles (RD grant, WAIT×2, WR grant).

## Configuration
- FB_SCROLL_FILL_EN defined: after the copy, the last N rows are written with FILL_CHAR before scroll_done.
- Not defined: the FILL state is removed and the vacated rows keep their old contents. scroll_done follows the last copy write; C=0 goes directly to DONE.

## Structure
- The shared package holds:
  - owner-tag enum: NONE, DISP, CPU, SCROLL
  - scroll state enum
  - screen geometry constants (H_CHARS, V_CHARS, SCREEN_CHARS)
- One sub-module, fb_scroll_engine, contains the state machine. It exposes req/we/addr/wdata/grant/rdata toward the arbiter core.

## Test plan
- Reset mid-scroll: RESET_N low for 1 cycle at copy index 200 → busy=0, no ram_we afterward, no done pulse.
- Display-only traffic: disp_req=1, addr 0..9 one per cycle → disp_valid 2 cycles later with matching bytes, 10 consecutive valid cycles, no gaps.
- CPU contention: cpu_req with addr 0x0050, data 0x41 while disp_req=1 → no ack. Drop disp_req → cpu_ack next edge, RAM[0x0050]=0x41.
- Scroll by 1: row k preloaded with byte k; scroll_lines=1 with blank=1 → RAM[0..4719] holds row+1 data. With FB_SCROLL_FILL_EN, RAM[4720..4799]=0x20, then done pulses once.
- Clamp and zero: scroll_lines=0 → done 1 cycle after start, no writes. scroll_lines=200 → C=0. With fill, all 4800 bytes=0x20; without, done with no writes.
- Blank stall: toggle blank every 50 cycles during a scroll by 3 → result identical to an unstalled run; ram_we never high for scroll while blank=0.

Source files
------------

// File: rtl/fb_port_arbiter_pkg.sv
// Shared types and screen geometry for the framebuffer port arbiter and scroll engine.
package fb_port_arbiter_pkg;

  localparam int unsigned H_CHARS      = 80;
  localparam int unsigned V_CHARS      = 60;
  localparam int unsigned SCREEN_CHARS = H_CHARS * V_CHARS;
  localparam logic [7:0]  FILL_CHAR    = 8'h20;

  // Owner tag carried alongside each RAM access until its read data returns
  typedef enum logic [1:0] {
    OwnNone,
    OwnDisp,
    OwnCpu,
    OwnScroll
  } owner_e;

  typedef logic [2:0] scroll_state_t;

  localparam scroll_state_t StIdle = 3'd0;
  localparam scroll_state_t StRd   = 3'd1;
  localparam scroll_state_t StWait = 3'd2;
  localparam scroll_state_t StWr   = 3'd3;
  localparam scroll_state_t StFill = 3'd4;
  localparam scroll_state_t StDone = 3'd5;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester, scroll-control and RAM-port signals of the framebuffer arbiter.
interface fb_port_arbiter_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [7:0]        disp_rdata;
  logic              disp_valid;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_ack;
  logic              blank;
  logic              scroll_start;
  logic [7:0]        scroll_lines;
  logic              scroll_busy;
  logic              scroll_done;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_addr, cpu_wdata, blank,
    input  scroll_start, scroll_lines, ram_rdata,
    output disp_rdata, disp_valid, cpu_ack, scroll_busy, scroll_done,
    output ram_addr, ram_we, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_addr, cpu_wdata, blank,
    output scroll_start, scroll_lines, ram_rdata,
    input  disp_rdata, disp_valid, cpu_ack, scroll_busy, scroll_done,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_scroll_engine.sv
// Scroll/copy sequencer: moves rows up by N and, with FB_SCROLL_FILL_EN, fills the vacated rows.
module fb_scroll_engine
  import fb_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [7:0]        lines_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        wdata_o,
  input  logic              grant_i,
  input  logic              rvalid_i,
  input  logic [7:0]        rdata_i
);

`ifdef FB_SCROLL_FILL_EN
  localparam scroll_state_t AfterCopy = StFill;
`else
  localparam scroll_state_t AfterCopy = StDone;
`endif

  scroll_state_t state_q, state_d;
  logic [13:0]   dst_q, dst_d, cnt_q, cnt_d, off_q, off_d;
  logic [7:0]    data_q, data_d;
  logic [13:0]   lines_ext, n_rows, cnt_new, dst_inc;

  assign lines_ext = {6'd0, lines_i};
  assign n_rows    = (lines_ext > 14'(V_CHARS)) ? 14'(V_CHARS) : lines_ext;
  assign cnt_new   = (14'(V_CHARS) - n_rows) * 14'(H_CHARS);
  assign dst_inc   = dst_q + 14'd1;

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          dst_d = '0;
          cnt_d = cnt_new;
          off_d = n_rows * 14'(H_CHARS);
          if (n_rows == '0)       state_d = StDone;
          else if (cnt_new == '0) state_d = AfterCopy;
          else                    state_d = StRd;
        end
      end
      StRd:   if (grant_i) state_d = StWait;
      StWait: begin
        if (rvalid_i) begin
          data_d  = rdata_i;
          state_d = StWr;
        end
      end
      StWr: begin
        if (grant_i) begin
          dst_d   = dst_inc;
          state_d = (dst_inc < cnt_q) ? StRd : AfterCopy;
        end
      end
`ifdef FB_SCROLL_FILL_EN
      StFill: begin
        if (grant_i) begin
          dst_d = dst_inc;
          if (dst_inc == 14'(SCREEN_CHARS)) state_d = StDone;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      dst_q   <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      data_q  <= data_d;
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign done_o  = (state_q == StDone);
  assign req_o   = (state_q == StRd) || (state_q == StWr) || (state_q == StFill);
  assign we_o    = (state_q == StWr) || (state_q == StFill);
  assign addr_o  = ADDR_W'((state_q == StRd) ? (dst_q + off_q) : dst_q);
`ifdef FB_SCROLL_FILL_EN
  assign wdata_o = (state_q == StFill) ? FILL_CHAR : data_q;
`else
  assign wdata_o = data_q;
`endif

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: display > CPU > scroll. Fill build option: FB_SCROLL_FILL_EN.
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 13
) (
  input logic               CLK_FAST,
  input logic               RESET_N,
  fb_port_arbiter_if.slave  bus
);

  logic              scr_req, scr_we;
  logic [ADDR_W-1:0] scr_addr;
  logic [7:0]        scr_wdata;
  logic              cpu_active, grant_disp, grant_cpu, grant_scr;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, lock_addr_q, lock_addr_d;
  logic [7:0]        ram_wdata_q, ram_wdata_d, lock_data_q, lock_data_d;
  logic [7:0]        disp_rdata_q, disp_rdata_d;
  logic              ram_we_q, ram_we_d, cpu_ack_q, cpu_ack_d;
  logic              cpu_lock_q, cpu_lock_d, disp_valid_q;
  owner_e            tag1_q, tag1_d, tag2_q;

  fb_scroll_engine #(
    .ADDR_W (ADDR_W)
  ) u_scroll (
    .clk_i    (CLK_FAST),
    .rst_ni   (RESET_N),
    .start_i  (bus.scroll_start),
    .lines_i  (bus.scroll_lines),
    .busy_o   (bus.scroll_busy),
    .done_o   (bus.scroll_done),
    .req_o    (scr_req),
    .we_o     (scr_we),
    .addr_o   (scr_addr),
    .wdata_o  (scr_wdata),
    .grant_i  (grant_scr),
    .rvalid_i (tag2_q == OwnScroll),
    .rdata_i  (bus.ram_rdata)
  );

  // A held request that was already acked is not active until it drops or changes
  assign cpu_active = bus.cpu_req && !(cpu_lock_q && (bus.cpu_addr == lock_addr_q) &&
                                       (bus.cpu_wdata == lock_data_q));
  assign grant_disp = bus.disp_req;
  assign grant_cpu  = !bus.disp_req && cpu_active;
  assign grant_scr  = !bus.disp_req && !cpu_active && bus.blank && scr_req;

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag1_d      = OwnNone;
    cpu_ack_d   = 1'b0;
    lock_addr_d = lock_addr_q;
    lock_data_d = lock_data_q;
    cpu_lock_d  = bus.cpu_req ? cpu_lock_q : 1'b0;
    if (grant_disp) begin
      ram_addr_d = bus.disp_addr;
      tag1_d     = OwnDisp;
    end else if (grant_cpu) begin
      ram_addr_d  = bus.cpu_addr;
      ram_we_d    = 1'b1;
      ram_wdata_d = bus.cpu_wdata;
      tag1_d      = OwnCpu;
      cpu_ack_d   = 1'b1;
      cpu_lock_d  = 1'b1;
      lock_addr_d = bus.cpu_addr;
      lock_data_d = bus.cpu_wdata;
    end else if (grant_scr) begin
      ram_addr_d = scr_addr;
      ram_we_d   = scr_we;
      if (scr_we) ram_wdata_d = scr_wdata;
      tag1_d     = scr_we ? OwnNone : OwnScroll;
    end
    disp_rdata_d = (tag2_q == OwnDisp) ? bus.ram_rdata : disp_rdata_q;
  end

  always_ff @(posedge CLK_FAST or negedge RESET_N) begin
    if (!RESET_N) begin
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_lock_q   <= 1'b0;
      lock_addr_q  <= '0;
      lock_data_q  <= '0;
      tag1_q       <= OwnNone;
      tag2_q       <= OwnNone;
      disp_valid_q <= 1'b0;
      disp_rdata_q <= '0;
    end else begin
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_lock_q   <= cpu_lock_d;
      lock_addr_q  <= lock_addr_d;
      lock_data_q  <= lock_data_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
      disp_valid_q <= (tag2_q == OwnDisp);
      disp_rdata_q <= disp_rdata_d;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_rdata = disp_rdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter with a behavioural one-cycle-latency BRAM.
module tb_fb_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic load_en = 1'b0;
  always #5 clk = ~clk;

  fb_port_arbiter_if #(.ADDR_W(13)) bus_if ();

  fb_port_arbiter #(
    .ADDR_W (13)
  ) dut (
    .CLK_FAST (clk),
    .RESET_N  (rst_n),
    .bus      (bus_if)
  );

  logic [7:0] mem [8192];
  logic [7:0] model [4800];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 8192; i++) mem[i] <= (i < 4800) ? 8'(i / 80) : 8'hEE;
    end else begin
      bus_if.ram_rdata <= mem[bus_if.ram_addr];
      if (bus_if.ram_we) mem[bus_if.ram_addr] <= bus_if.ram_wdata;
    end
  end

  int unsigned cyc = 0;
  logic blank_e = 1'b0;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    blank_e <= bus_if.blank;
  end

  // Scoreboard queues: stimulus pushes, monitor pops
  string       chk_name[$];
  int          chk_act[$];
  int          chk_exp[$];
  int          dexp_data[$];
  int unsigned dexp_due[$];
  int          cexp_addr[$];
  int          cexp_data[$];
  int unsigned cexp_due[$];

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0, we_cnt = 0, ack_cnt = 0, viol = 0, run = 0, last_run = 0;
  int unsigned last_done_cyc = 0;

  task automatic do_check(input string n, input int a, input int e);
    n_checks++;
    if (a != e) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    while (chk_name.size() > 0)
      do_check(chk_name.pop_front(), chk_act.pop_front(), chk_exp.pop_front());
    if (rst_n) begin
      if (bus_if.disp_valid) begin
        run++;
        if (dexp_data.size() == 0) do_check("disp_unexpected", 1, 0);
        else begin
          do_check("disp_data", int'(bus_if.disp_rdata), dexp_data.pop_front());
          do_check("disp_latency", int'(cyc), int'(dexp_due.pop_front()));
        end
      end else if (run > 0) begin
        last_run = run;
        run      = 0;
      end
      if (bus_if.cpu_ack) begin
        ack_cnt++;
        if (cexp_addr.size() == 0) do_check("cpu_unexpected_ack", 1, 0);
        else begin
          do_check("cpu_addr", int'(bus_if.ram_addr), cexp_addr.pop_front());
          do_check("cpu_wdata", int'(bus_if.ram_wdata), cexp_data.pop_front());
          do_check("cpu_ack_cycle", int'(cyc), int'(cexp_due.pop_front()));
        end
      end
      if (bus_if.scroll_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (bus_if.ram_we) begin
        we_cnt++;
        if (!blank_e && bus_if.scroll_busy) viol++;
      end
    end
  end

  task automatic push_chk(input string n, input int a, input int e);
    chk_name.push_back(n);
    chk_act.push_back(a);
    chk_exp.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp_read(input int a);
    bus_if.disp_req  = 1'b1;
    bus_if.disp_addr = 13'(a);
    dexp_data.push_back(int'(model[a]));
    dexp_due.push_back(cyc + 3);
    tick();
  endtask

  task automatic preload();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    for (int i = 0; i < 4800; i++) model[i] = 8'(i / 80);
  endtask

  task automatic start_scroll(input int lines);
    bus_if.scroll_start = 1'b1;
    bus_if.scroll_lines = 8'(lines);
    tick();
    bus_if.scroll_start = 1'b0;
  endtask

  task automatic model_scroll(input int lines);
    int n, c;
    n = (lines > 60) ? 60 : lines;
    c = (60 - n) * 80;
    for (int i = 0; i < c; i++) model[i] = model[i + n * 80];
`ifdef FB_SCROLL_FILL_EN
    for (int i = c; i < 4800; i++) model[i] = 8'h20;
`endif
  endtask

  task automatic check_region(input string n, input int lo, input int hi);
    int mism = 0;
    for (int i = lo; i <= hi; i++) if (mem[i] !== model[i]) mism++;
    push_chk(n, mism, 0);
  endtask

  task automatic wait_done(input string n, input int bound);
    int d0 = done_cnt;
    int t = 0;
    while (done_cnt == d0 && t < bound) begin
      tick();
      t++;
    end
    push_chk(n, int'(t < bound), 1);
  endtask

  int k, d0, w0, a0, v0, fill_w;

  initial begin
    bus_if.disp_req = 0; bus_if.disp_addr = 0; bus_if.cpu_req = 0; bus_if.cpu_addr = 0;
    bus_if.cpu_wdata = 0; bus_if.blank = 0; bus_if.scroll_start = 0; bus_if.scroll_lines = 0;
`ifdef FB_SCROLL_FILL_EN
    fill_w = 1;
`else
    fill_w = 0;
`endif
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    push_chk("rst_disp_valid", int'(bus_if.disp_valid), 0);
    push_chk("rst_disp_rdata", int'(bus_if.disp_rdata), 0);
    push_chk("rst_cpu_ack", int'(bus_if.cpu_ack), 0);
    push_chk("rst_scroll_busy", int'(bus_if.scroll_busy), 0);
    push_chk("rst_scroll_done", int'(bus_if.scroll_done), 0);
    push_chk("rst_ram_we", int'(bus_if.ram_we), 0);
    push_chk("rst_ram_addr", int'(bus_if.ram_addr), 0);
    push_chk("rst_ram_wdata", int'(bus_if.ram_wdata), 0);
    preload();

    // Reset mid-scroll
    bus_if.blank = 1'b1;
    start_scroll(1);
    w0 = we_cnt;
    k = 0;
    while (we_cnt - w0 < 200 && k < 3000) begin tick(); k++; end
    push_chk("abort_reach_200", int'(k < 3000), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push_chk("abort_busy", int'(bus_if.scroll_busy), 0);
    w0 = we_cnt; d0 = done_cnt;
    repeat (50) tick();
    push_chk("abort_no_writes", we_cnt - w0, 0);
    push_chk("abort_no_done", done_cnt - d0, 0);
    bus_if.blank = 1'b0;
    preload();

    // Display-only traffic
    for (int a = 0; a < 10; a++) disp_read(a);
    bus_if.disp_req = 1'b0;
    repeat (5) tick();
    push_chk("disp_run_len", last_run, 10);

    // CPU contention
    bus_if.cpu_req = 1'b1; bus_if.cpu_addr = 13'h0050; bus_if.cpu_wdata = 8'h41;
    a0 = ack_cnt;
    for (int a = 0; a < 4; a++) disp_read(a);
    push_chk("cpu_no_ack_under_disp", ack_cnt - a0, 0);
    bus_if.disp_req = 1'b0;
    cexp_addr.push_back(32'h50); cexp_data.push_back(32'h41); cexp_due.push_back(cyc + 1);
    repeat (5) tick();
    bus_if.cpu_req = 1'b0;
    tick();
    push_chk("cpu_single_ack", ack_cnt - a0, 1);
    push_chk("cpu_mem", int'(mem[16'h50]), 32'h41);
    model[16'h50] = 8'h41;
    disp_read(16'h50);
    bus_if.disp_req = 1'b0;
    repeat (4) tick();

    // Scroll by 1
    preload();
    bus_if.blank = 1'b1;
    w0 = we_cnt; d0 = done_cnt;
    start_scroll(1);
    wait_done("scroll1_done", 25000);
    repeat (3) tick();
    model_scroll(1);
    push_chk("scroll1_done_once", done_cnt - d0, 1);
    push_chk("scroll1_busy_after", int'(bus_if.scroll_busy), 0);
    push_chk("scroll1_writes", we_cnt - w0, 4720 + fill_w * 80);
    check_region("scroll1_copy", 0, 4719);
    check_region("scroll1_tail", 4720, 4799);

    // Scroll by 0
    w0 = we_cnt; d0 = done_cnt;
    k = int'(cyc);
    start_scroll(0);
    repeat (3) tick();
    push_chk("scroll0_done_cycle", int'(last_done_cyc), k + 1);
    push_chk("scroll0_done_once", done_cnt - d0, 1);
    push_chk("scroll0_no_writes", we_cnt - w0, 0);

    // Scroll by 3 with blank toggling every 50 cycles
    w0 = we_cnt; d0 = done_cnt; v0 = viol;
    start_scroll(3);
    k = 0;
    while (done_cnt == d0 && k < 60000) begin
      tick();
      k++;
      if (k % 50 == 0) bus_if.blank = ~bus_if.blank;
    end
    push_chk("scroll3_done", int'(k < 60000), 1);
    bus_if.blank = 1'b1;
    repeat (3) tick();
    model_scroll(3);
    push_chk("scroll3_blank_viol", viol - v0, 0);
    push_chk("scroll3_writes", we_cnt - w0, 4560 + fill_w * 240);
    check_region("scroll3_result", 0, 4799);

    // Scroll by 200 clamps to a full-screen scroll
    w0 = we_cnt; d0 = done_cnt;
    start_scroll(200);
    wait_done("scroll200_done", 6000);
    repeat (3) tick();
    model_scroll(200);
    push_chk("scroll200_done_once", done_cnt - d0, 1);
    push_chk("scroll200_writes", we_cnt - w0, fill_w * 4800);
    check_region("scroll200_result", 0, 4799);

    push_chk("disp_queue_drained", dexp_data.size(), 0);
    push_chk("cpu_queue_drained", cexp_addr.size(), 0);
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
